dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the datapath load/store path (core) and a host/debug port (program loader, memory inspection).
- Holds the core on a stall while the core's access is outstanding.
- Uses a three-state sequencer (IDLE/ACCESS/RESP) with a configurable memory access latency.
- Sits between the execute-stage address/data outputs and the data memory block.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_pick.sv | 44 ++++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : sequencer states (IDLE, ACCESS, RESP)
//   OWN_CORE/OWN_HOST : owner encoding used for grants and last_grant
//   LAT_W : width of the access-latency down-counter (MEM_LAT up to 15)
package dmem_arb_pkg;

   localparam int unsigned LAT_W = 4;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_HOST = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_pick.sv
// Two-way winner selection between the core and the host requester.
// Optional feature macro: DMEM_ARB_FIXED_PRIO_EN (core always wins ties;
// otherwise ties alternate against last_grant).
// Ports:
//   core_req, host_req : pending requests
//   last_grant         : owner of the most recent grant
//   any_req_c          : at least one request pending (combinational)
//   winner_c           : selected owner, OWN_CORE/OWN_HOST (combinational)
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic core_req,
   input  logic host_req,
   input  logic last_grant,
   output logic any_req_c,
   output logic winner_c
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   // Core has absolute priority; host only wins when the core is silent.
   always_comb begin
      any_req_c = core_req | host_req;
      winner_c  = OWN_CORE;
      if (!core_req) begin
         winner_c = OWN_HOST;
      end
   end
`else
   // Round-robin: on a tie the requester that was not served last wins.
   always_comb begin
      any_req_c = core_req | host_req;
      winner_c  = OWN_CORE;
      if (core_req && host_req) begin
         winner_c = (last_grant == OWN_CORE) ? OWN_HOST : OWN_CORE;
      end else if (host_req) begin
         winner_c = OWN_HOST;
      end
   end
`endif

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and
// the host/debug port. IDLE -> ACCESS (MEM_LAT cycles) -> RESP (ack) -> IDLE.
// Optional feature macro: DMEM_ARB_FIXED_PRIO_EN (see dmem_arb_pick).
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   core_req/we/addr/wdata        : core request, held until core_ack
//   core_rdata, core_ack          : core load data and completion pulse
//   core_stall                    : core_req & ~core_ack (combinational)
//   host_req/we/addr/wdata        : host request, held until host_ack
//   host_rdata, host_ack          : host load data and completion pulse
//   mem_addr/wdata/read/write     : memory interface, active only in ACCESS
//   mem_rdata                     : combinational memory read data
//   busy                          : sequencer not idle
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_ack,
   output logic              core_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_e       state;
   logic [LAT_W-1:0] lat_cnt;
   logic             last_grant;
   logic             owner_q;
   logic             we_q;

   logic              any_req_c;
   logic              winner_c;
   logic              sel_we_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;

   dmem_arb_pick u_pick (
      .core_req   (core_req),
      .host_req   (host_req),
      .last_grant (last_grant),
      .any_req_c  (any_req_c),
      .winner_c   (winner_c)
   );

   // Request fields of the current winner.
   always_comb begin
      sel_we_c    = core_we;
      sel_addr_c  = core_addr;
      sel_wdata_c = core_wdata;
      if (winner_c == OWN_HOST) begin
         sel_we_c    = host_we;
         sel_addr_c  = host_addr;
         sel_wdata_c = host_wdata;
      end
   end

   // The core advances on the ack edge, so the stall drops during the ack cycle.
   assign core_stall = core_req & ~core_ack;

   // Sequencer with registered memory strobes, acks and read-data capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         last_grant <= OWN_HOST;
         owner_q    <= OWN_CORE;
         we_q       <= 1'b0;
         core_rdata <= '0;
         core_ack   <= 1'b0;
         host_rdata <= '0;
         host_ack   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         core_ack <= 1'b0;
         host_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req_c) begin
                  owner_q    <= winner_c;
                  last_grant <= winner_c;
                  we_q       <= sel_we_c;
                  mem_addr   <= sel_addr_c;
                  mem_wdata  <= sel_wdata_c;
                  mem_read   <= ~sel_we_c;
                  // With a single-cycle access the first ACCESS cycle is also the last.
                  mem_write  <= sel_we_c & (MEM_LAT == 1);
                  lat_cnt    <= LAT_W'(MEM_LAT - 1);
                  busy       <= 1'b1;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat_cnt == '0) begin
                  if (!we_q) begin
                     if (owner_q == OWN_HOST) begin
                        host_rdata <= mem_rdata;
                     end else begin
                        core_rdata <= mem_rdata;
                     end
                  end
                  core_ack  <= (owner_q == OWN_CORE);
                  host_ack  <= (owner_q == OWN_HOST);
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= RESP;
               end else begin
                  lat_cnt   <= lat_cnt - LAT_W'(1);
                  // Write strobe only in the cycle where lat_cnt reaches zero.
                  mem_write <= we_q & (lat_cnt == LAT_W'(1));
               end
            end
            RESP: begin
               // Requests are deliberately not sampled here.
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter. Three instances (MEM_LAT =
// 1, 2, 3) share all inputs; each vector names the instance it checks.
module tb_dmem_arbiter;

   localparam int unsigned NI = 3;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        core_req, core_we, host_req, host_we;
   logic [31:0] core_addr, core_wdata, host_addr, host_wdata, mem_rdata;

   logic [31:0] core_rdata_a [NI];
   logic [31:0] host_rdata_a [NI];
   logic [31:0] mem_addr_a   [NI];
   logic [31:0] mem_wdata_a  [NI];
   logic        core_ack_a   [NI];
   logic        core_stall_a [NI];
   logic        host_ack_a   [NI];
   logic        mem_read_a   [NI];
   logic        mem_write_a  [NI];
   logic        busy_a       [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_arbiter #(
         .ADDR_W  (32),
         .DATA_W  (32),
         .MEM_LAT (g + 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .core_req   (core_req),
         .core_we    (core_we),
         .core_addr  (core_addr),
         .core_wdata (core_wdata),
         .core_rdata (core_rdata_a[g]),
         .core_ack   (core_ack_a[g]),
         .core_stall (core_stall_a[g]),
         .host_req   (host_req),
         .host_we    (host_we),
         .host_addr  (host_addr),
         .host_wdata (host_wdata),
         .host_rdata (host_rdata_a[g]),
         .host_ack   (host_ack_a[g]),
         .mem_addr   (mem_addr_a[g]),
         .mem_wdata  (mem_wdata_a[g]),
         .mem_read   (mem_read_a[g]),
         .mem_write  (mem_write_a[g]),
         .mem_rdata  (mem_rdata),
         .busy       (busy_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic        rst;
      logic        c_req, c_we;
      logic [31:0] c_addr, c_wdata;
      logic        h_req, h_we;
      logic [31:0] h_addr, h_wdata;
      logic [31:0] m_rdata;
      logic        e_cack, e_hack, e_stall, e_mrd, e_mwr, e_busy;
      logic [31:0] e_maddr, e_mwdata, e_crd, e_hrd;
   } vec_t;

   vec_t vq[$];
   vec_t cur;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic vin(input string nm, input int sel, input logic r,
                      input logic creq, input logic cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input logic hreq, input logic hwe,
                      input logic [31:0] haddr, input logic [31:0] hwd,
                      input logic [31:0] mrd);
      cur.name = nm; cur.sel = sel; cur.rst = r;
      cur.c_req = creq; cur.c_we = cwe; cur.c_addr = caddr; cur.c_wdata = cwd;
      cur.h_req = hreq; cur.h_we = hwe; cur.h_addr = haddr; cur.h_wdata = hwd;
      cur.m_rdata = mrd;
   endtask

   task automatic vexp(input logic cack, input logic hack, input logic stall,
                       input logic mrd, input logic mwr, input logic bsy,
                       input logic [31:0] maddr, input logic [31:0] mwd,
                       input logic [31:0] crd, input logic [31:0] hrd);
      cur.e_cack = cack; cur.e_hack = hack; cur.e_stall = stall;
      cur.e_mrd = mrd; cur.e_mwr = mwr; cur.e_busy = bsy;
      cur.e_maddr = maddr; cur.e_mwdata = mwd; cur.e_crd = crd; cur.e_hrd = hrd;
      vq.push_back(cur);
   endtask

   task automatic fill();
      // Core load, MEM_LAT=1
      vin("t1_rst", 0, 0, 0,0,0,0, 0,0,0,0, 0);           vexp(0,0,0,0,0,0, 0,0,0,0);
      vin("t1_grant", 0, 1, 1,0,32'h10,0, 0,0,0,0, 4);    vexp(0,0,1,1,0,1, 32'h10,0,0,0);
      vin("t1_ack", 0, 1, 1,0,32'h10,0, 0,0,0,0, 4);      vexp(1,0,0,0,0,1, 0,0,4,0);
      vin("t1_idle", 0, 1, 0,0,0,0, 0,0,0,0, 0);          vexp(0,0,0,0,0,0, 0,0,4,0);
      // Host store, MEM_LAT=3
      vin("t2_rst", 2, 0, 0,0,0,0, 0,0,0,0, 0);           vexp(0,0,0,0,0,0, 0,0,0,0);
      vin("t2_acc1", 2, 1, 0,0,0,0, 1,1,32'h20,32'hDEADBEEF, 0);
      vexp(0,0,0,0,0,1, 32'h20,32'hDEADBEEF,0,0);
      vin("t2_acc2", 2, 1, 0,0,0,0, 1,1,32'h20,32'hDEADBEEF, 0);
      vexp(0,0,0,0,0,1, 32'h20,32'hDEADBEEF,0,0);
      vin("t2_acc3", 2, 1, 0,0,0,0, 1,1,32'h20,32'hDEADBEEF, 0);
      vexp(0,0,0,0,1,1, 32'h20,32'hDEADBEEF,0,0);
      vin("t2_ack", 2, 1, 0,0,0,0, 1,1,32'h20,32'hDEADBEEF, 0);
      vexp(0,1,0,0,0,1, 0,0,0,0);
      vin("t2_idle", 2, 1, 0,0,0,0, 0,0,0,0, 0);          vexp(0,0,0,0,0,0, 0,0,0,0);
      // Simultaneous core/host loads, MEM_LAT=1
      vin("t3_rst", 0, 0, 0,0,0,0, 0,0,0,0, 0);           vexp(0,0,0,0,0,0, 0,0,0,0);
      vin("t3_g1", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
      vexp(0,0,1,1,0,1, 32'h100,0,0,0);
      vin("t3_a1", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 32'hA1);
      vexp(1,0,0,0,0,1, 0,0,32'hA1,0);
      vin("t3_i1", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
      vexp(0,0,1,0,0,0, 0,0,32'hA1,0);
      if (FIXED) begin
         vin("t3_g2", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
         vexp(0,0,1,1,0,1, 32'h100,0,32'hA1,0);
         vin("t3_a2", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 32'hB2);
         vexp(1,0,0,0,0,1, 0,0,32'hB2,0);
         vin("t3_i2", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
         vexp(0,0,1,0,0,0, 0,0,32'hB2,0);
         vin("t3_g3", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
         vexp(0,0,1,1,0,1, 32'h100,0,32'hB2,0);
         vin("t3_a3", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 32'hC3);
         vexp(1,0,0,0,0,1, 0,0,32'hC3,0);
      end else begin
         vin("t3_g2", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
         vexp(0,0,1,1,0,1, 32'h200,0,32'hA1,0);
         vin("t3_a2", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 32'hB2);
         vexp(0,1,1,0,0,1, 0,0,32'hA1,32'hB2);
         vin("t3_i2", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
         vexp(0,0,1,0,0,0, 0,0,32'hA1,32'hB2);
         vin("t3_g3", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 0);
         vexp(0,0,1,1,0,1, 32'h100,0,32'hA1,32'hB2);
         vin("t3_a3", 0, 1, 1,0,32'h100,0, 1,0,32'h200,0, 32'hC3);
         vexp(1,0,0,0,0,1, 0,0,32'hC3,32'hB2);
      end
      // Reset during a core store, MEM_LAT=2
      vin("t4_rst", 1, 0, 0,0,0,0, 0,0,0,0, 0);           vexp(0,0,0,0,0,0, 0,0,0,0);
      vin("t4_acc1", 1, 1, 1,1,32'h30,32'h55, 0,0,0,0, 0);
      vexp(0,0,1,0,0,1, 32'h30,32'h55,0,0);
      vin("t4_abort", 1, 0, 0,0,0,0, 0,0,0,0, 0);         vexp(0,0,0,0,0,0, 0,0,0,0);
      vin("t4_after", 1, 1, 0,0,0,0, 0,0,0,0, 0);         vexp(0,0,0,0,0,0, 0,0,0,0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      vec_t v;
      int   s;
      int   lat;
      bit   got;

      rst = 1'b0;
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      mem_rdata = 0;

      fill();
      foreach (vq[i]) begin
         v = vq[i];
         rst = v.rst;
         core_req = v.c_req; core_we = v.c_we; core_addr = v.c_addr; core_wdata = v.c_wdata;
         host_req = v.h_req; host_we = v.h_we; host_addr = v.h_addr; host_wdata = v.h_wdata;
         mem_rdata = v.m_rdata;
         step();
         s = v.sel;
         chk({v.name, "_core_ack"},   32'(core_ack_a[s]),   32'(v.e_cack));
         chk({v.name, "_host_ack"},   32'(host_ack_a[s]),   32'(v.e_hack));
         chk({v.name, "_core_stall"}, 32'(core_stall_a[s]), 32'(v.e_stall));
         chk({v.name, "_mem_read"},   32'(mem_read_a[s]),   32'(v.e_mrd));
         chk({v.name, "_mem_write"},  32'(mem_write_a[s]),  32'(v.e_mwr));
         chk({v.name, "_busy"},       32'(busy_a[s]),       32'(v.e_busy));
         chk({v.name, "_mem_addr"},   mem_addr_a[s],        v.e_maddr);
         chk({v.name, "_mem_wdata"},  mem_wdata_a[s],       v.e_mwdata);
         chk({v.name, "_core_rdata"}, core_rdata_a[s],      v.e_crd);
         chk({v.name, "_host_rdata"}, host_rdata_a[s],      v.e_hrd);
      end

      // Core holds req through RESP, then re-requests 0x24 (MEM_LAT=1 instance).
      rst = 1'b0;
      core_req = 0; host_req = 0; core_we = 0; mem_rdata = 0;
      step();
      rst = 1'b1;
      core_req = 1; core_addr = 32'h20; mem_rdata = 32'h77;
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10 && !got; c++) begin
         step();
         if (core_ack_a[0] === 1'b1) begin
            got = 1'b1;
            lat = c;
         end
      end
      chk("t5_ack_seen", 32'(got), 32'd1);
      chk("t5_ack_latency", 32'(lat), 32'd2);
      chk("t5_rdata1", core_rdata_a[0], 32'h77);
      step();
      chk("t5_resp_no_grant_busy", 32'(busy_a[0]), 32'd0);
      chk("t5_resp_no_grant_read", 32'(mem_read_a[0]), 32'd0);
      chk("t5_resp_no_ack", 32'(core_ack_a[0]), 32'd0);
      chk("t5_idle_stall", 32'(core_stall_a[0]), 32'd1);
      core_addr = 32'h24;
      mem_rdata = 32'h88;
      step();
      chk("t5_regrant_read", 32'(mem_read_a[0]), 32'd1);
      chk("t5_regrant_addr", mem_addr_a[0], 32'h24);
      chk("t5_regrant_busy", 32'(busy_a[0]), 32'd1);
      step();
      chk("t5_ack2", 32'(core_ack_a[0]), 32'd1);
      chk("t5_rdata2", core_rdata_a[0], 32'h88);
      core_req = 0;
      step();
      chk("t5_final_idle", 32'(busy_a[0]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_dmem_arbiter
